decode_queue: RTL and testbench

//  Parametrised, buffered decode stage between fetch and rename. Decodes up to FETCH_W fetched

---
 rtl/decode_queue.sv | 236 +++++++++++++++++++++++
 tb/tb_decode_queue.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : decode_queue
// Purpose  : Decodes up to FETCH_W instructions per cycle into micro-op records,
//            compacts holes and buffers them in a circular queue feeding rename.
// Revision : 1.0 - initial release
// ============================================================================
module decode_queue #(
    parameter int FETCH_W    = 2,
    parameter int DISPATCH_W = 2,
    parameter int DEPTH      = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               flush,
    input  logic [FETCH_W-1:0]                 fetch_valid,
    input  logic [FETCH_W-1:0][31:0]           fetch_instr,
    input  logic [FETCH_W-1:0][31:0]           fetch_pc,
    output logic                               fetch_ready,
    output logic [DISPATCH_W-1:0]              out_valid,
    input  logic                               out_ready,
    output logic [DISPATCH_W-1:0][5:0]         out_opcode,
    output logic [DISPATCH_W-1:0][4:0]         out_rs1,
    output logic [DISPATCH_W-1:0][4:0]         out_rs2,
    output logic [DISPATCH_W-1:0][4:0]         out_rd,
    output logic [DISPATCH_W-1:0]              out_rs1_valid,
    output logic [DISPATCH_W-1:0]              out_rs2_valid,
    output logic [DISPATCH_W-1:0]              out_rd_valid,
    output logic [DISPATCH_W-1:0][31:0]        out_imm,
    output logic [DISPATCH_W-1:0][31:0]        out_pc,
    output logic [DISPATCH_W-1:0][5:0]         out_alu_func,
    output logic [DISPATCH_W-1:0][4:0]         out_shamt,
    output logic [DISPATCH_W-1:0]              out_is_alu,
    output logic [DISPATCH_W-1:0]              out_is_load,
    output logic [DISPATCH_W-1:0]              out_is_store,
    output logic [DISPATCH_W-1:0]              out_is_branch,
    output logic [DISPATCH_W-1:0]              out_is_cas,
    output logic [DISPATCH_W-1:0]              out_is_link,
    output logic [DISPATCH_W-1:0]              out_is_svc,
    output logic [DISPATCH_W-1:0]              out_is_illegal,
    output logic [$clog2(DEPTH):0]             occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] c_ready_thr = OCC_W'(DEPTH - FETCH_W);
    localparam logic [OCC_W-1:0] c_disp_w    = OCC_W'(DISPATCH_W);

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rs1_v;
        logic        rs2_v;
        logic        rd_v;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [5:0]  alu_func;
        logic [4:0]  shamt;
        logic        is_alu;
        logic        is_load;
        logic        is_store;
        logic        is_branch;
        logic        is_cas;
        logic        is_link;
        logic        is_svc;
        logic        is_illegal;
    } rec_t;

    function automatic rec_t f_decode(input logic [31:0] instr, input logic [31:0] pc);
        rec_t r;
        r        = '0;
        r.opcode = instr[31:26];
        r.pc     = pc;
        case (instr[31:26])
            6'b000000: begin
                r.rd       = instr[25:21];
                r.rs1      = instr[20:16];
                r.rs2      = instr[15:11];
                r.rd_v     = 1'b1;
                r.rs1_v    = 1'b1;
                r.rs2_v    = 1'b1;
                r.shamt    = instr[10:6];
                r.alu_func = instr[5:0];
                r.is_alu   = 1'b1;
            end
            6'b001000, 6'b001001, 6'b001010, 6'b001011, 6'b001100: begin
                r.rd     = instr[25:21];
                r.rs1    = instr[20:16];
                r.rd_v   = 1'b1;
                r.rs1_v  = 1'b1;
                r.imm    = {{16{instr[15]}}, instr[15:0]};
                r.is_alu = 1'b1;
            end
            6'b010000, 6'b010010: begin
                r.rd      = instr[25:21];
                r.rs1     = instr[20:16];
                r.rd_v    = 1'b1;
                r.rs1_v   = 1'b1;
                r.imm     = {{16{instr[15]}}, instr[15:0]};
                r.is_load = 1'b1;
            end
            6'b010001, 6'b010011: begin
                // Stores carry the data register in the rd slot of the encoding.
                r.rs1      = instr[20:16];
                r.rs2      = instr[25:21];
                r.rs1_v    = 1'b1;
                r.rs2_v    = 1'b1;
                r.imm      = {{16{instr[15]}}, instr[15:0]};
                r.is_store = 1'b1;
            end
            6'b010100: begin
                r.rd     = instr[25:21];
                r.rs1    = instr[20:16];
                r.rs2    = instr[15:11];
                r.rd_v   = 1'b1;
                r.rs1_v  = 1'b1;
                r.rs2_v  = 1'b1;
                r.is_cas = 1'b1;
            end
            6'b100000, 6'b100001: begin
                r.imm       = {{4{instr[25]}}, instr[25:0], 2'b00};
                r.is_branch = 1'b1;
                if (instr[26]) begin
                    r.rd      = 5'd30;
                    r.rd_v    = 1'b1;
                    r.is_link = 1'b1;
                end
            end
            6'b100010, 6'b100011: begin
                r.rs1       = instr[25:21];
                r.rs1_v     = 1'b1;
                r.imm       = {{9{instr[20]}}, instr[20:0], 2'b00};
                r.is_branch = 1'b1;
            end
            6'b111000: begin
                r.imm    = {{6{instr[25]}}, instr[25:0]};
                r.is_svc = 1'b1;
            end
            6'b111111: begin
            end
            default: begin
                r.is_illegal = 1'b1;
            end
        endcase
        return r;
    endfunction

    rec_t                          r_mem [DEPTH];
    logic [PTR_W-1:0]              r_head;
    logic [PTR_W-1:0]              r_tail;
    logic [OCC_W-1:0]              r_occ;

    rec_t [FETCH_W-1:0]            w_dec;
    logic [FETCH_W-1:0][PTR_W-1:0] w_enq_off;
    logic [OCC_W-1:0]              w_enq_cnt;
    logic [OCC_W-1:0]              w_deq_cnt;
    logic                          w_fetch_ready;
    rec_t [DISPATCH_W-1:0]         w_lane;

    for (genvar i = 0; i < FETCH_W; i++) begin : g_dec
        assign w_dec[i] = f_decode(fetch_instr[i], fetch_pc[i]);
    end

    // Compaction: each valid lane lands at tail + (number of valid lanes below it).
    always_comb begin
        logic [OCC_W-1:0] v_acc;
        v_acc     = '0;
        w_enq_off = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            w_enq_off[i] = v_acc[PTR_W-1:0];
            if (fetch_valid[i]) begin
                v_acc = v_acc + 1'b1;
            end
        end
        w_enq_cnt = w_fetch_ready ? v_acc : '0;
    end

    assign w_fetch_ready = (r_occ <= c_ready_thr) && !flush;
    assign w_deq_cnt     = !out_ready ? '0 : ((r_occ >= c_disp_w) ? c_disp_w : r_occ);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else if (flush) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            r_head <= r_head + w_deq_cnt[PTR_W-1:0];
            r_tail <= r_tail + w_enq_cnt[PTR_W-1:0];
            r_occ  <= r_occ + w_enq_cnt - w_deq_cnt;
        end
    end

    // Storage needs no reset: every read is gated by occupancy.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_W; i++) begin
            if (w_fetch_ready && fetch_valid[i]) begin
                r_mem[r_tail + w_enq_off[i]] <= w_dec[i];
            end
        end
    end

    for (genvar k = 0; k < DISPATCH_W; k++) begin : g_out
        assign out_valid[k]      = r_occ > OCC_W'(k);
        assign w_lane[k]         = out_valid[k] ? r_mem[r_head + PTR_W'(k)] : '0;
        assign out_opcode[k]     = w_lane[k].opcode;
        assign out_rs1[k]        = w_lane[k].rs1;
        assign out_rs2[k]        = w_lane[k].rs2;
        assign out_rd[k]         = w_lane[k].rd;
        assign out_rs1_valid[k]  = w_lane[k].rs1_v;
        assign out_rs2_valid[k]  = w_lane[k].rs2_v;
        assign out_rd_valid[k]   = w_lane[k].rd_v;
        assign out_imm[k]        = w_lane[k].imm;
        assign out_pc[k]         = w_lane[k].pc;
        assign out_alu_func[k]   = w_lane[k].alu_func;
        assign out_shamt[k]      = w_lane[k].shamt;
        assign out_is_alu[k]     = w_lane[k].is_alu;
        assign out_is_load[k]    = w_lane[k].is_load;
        assign out_is_store[k]   = w_lane[k].is_store;
        assign out_is_branch[k]  = w_lane[k].is_branch;
        assign out_is_cas[k]     = w_lane[k].is_cas;
        assign out_is_link[k]    = w_lane[k].is_link;
        assign out_is_svc[k]     = w_lane[k].is_svc;
        assign out_is_illegal[k] = w_lane[k].is_illegal;
    end

    assign fetch_ready = w_fetch_ready;
    assign occupancy   = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_queue
// Purpose  : Directed vector table plus hand sequences for decode_queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_queue;

    logic             clk;
    logic             reset;
    logic             flush;
    logic [1:0]       fetch_valid;
    logic [1:0][31:0] fetch_instr;
    logic [1:0][31:0] fetch_pc;
    logic             fetch_ready;
    logic [1:0]       out_valid;
    logic             out_ready;
    logic [1:0][5:0]  out_opcode;
    logic [1:0][4:0]  out_rs1, out_rs2, out_rd;
    logic [1:0]       out_rs1_valid, out_rs2_valid, out_rd_valid;
    logic [1:0][31:0] out_imm, out_pc;
    logic [1:0][5:0]  out_alu_func;
    logic [1:0][4:0]  out_shamt;
    logic [1:0]       out_is_alu, out_is_load, out_is_store, out_is_branch;
    logic [1:0]       out_is_cas, out_is_link, out_is_svc, out_is_illegal;
    logic [3:0]       occupancy;

    int total = 0;
    int bad   = 0;

    decode_queue #(.FETCH_W(2), .DISPATCH_W(2), .DEPTH(8)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
        .fetch_ready(fetch_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_rs1_valid(out_rs1_valid), .out_rs2_valid(out_rs2_valid), .out_rd_valid(out_rd_valid),
        .out_imm(out_imm), .out_pc(out_pc), .out_alu_func(out_alu_func), .out_shamt(out_shamt),
        .out_is_alu(out_is_alu), .out_is_load(out_is_load), .out_is_store(out_is_store),
        .out_is_branch(out_is_branch), .out_is_cas(out_is_cas), .out_is_link(out_is_link),
        .out_is_svc(out_is_svc), .out_is_illegal(out_is_illegal), .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  v;      // {rd, rs1, rs2} valid
        logic [31:0] imm;
        logic [5:0]  func;
        logic [4:0]  sh;
        logic [7:0]  fl;     // {alu, load, store, branch, cas, link, svc, illegal}
    } vec_t;

    vec_t vt [16];
    logic [31:0] sb [$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [106:0] lane0_flat();
        return {out_opcode[0], out_rd[0], out_rs1[0], out_rs2[0],
                out_rd_valid[0], out_rs1_valid[0], out_rs2_valid[0],
                out_imm[0], out_pc[0], out_alu_func[0], out_shamt[0],
                out_is_alu[0], out_is_load[0], out_is_store[0], out_is_branch[0],
                out_is_cas[0], out_is_link[0], out_is_svc[0], out_is_illegal[0]};
    endfunction

    task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1);
        fetch_valid    = v;
        fetch_instr[0] = {6'b001000, 5'd1, 5'd1, pc0[15:0]};
        fetch_instr[1] = {6'b001000, 5'd2, 5'd2, pc1[15:0]};
        fetch_pc[0]    = pc0;
        fetch_pc[1]    = pc1;
    endtask

    initial begin
        logic [106:0] exp_flat;
        int           m_occ;
        logic [31:0]  tag;
        logic [31:0]  vec_pc;
        // ADDI, LDR, STR, R-type, CAS, B, CBZ, CBNZ, SVC, illegal, EORI, BL, LDUR, STUR, SUBI, illegal
        vt[0]  = '{{6'b001000, 5'd1, 5'd2, 16'hFFFC}, 5'd1, 5'd2, 5'd0, 3'b110, 32'hFFFF_FFFC, 6'h00, 5'd0, 8'h80};
        vt[1]  = '{{6'b010000, 5'd3, 5'd1, 16'h0008}, 5'd3, 5'd1, 5'd0, 3'b110, 32'h0000_0008, 6'h00, 5'd0, 8'h40};
        vt[2]  = '{{6'b010001, 5'd7, 5'd4, 16'h8000}, 5'd0, 5'd4, 5'd7, 3'b011, 32'hFFFF_8000, 6'h00, 5'd0, 8'h20};
        vt[3]  = '{{6'b000000, 5'd5, 5'd6, 5'd7, 5'd3, 6'h20}, 5'd5, 5'd6, 5'd7, 3'b111, 32'h0, 6'h20, 5'd3, 8'h80};
        vt[4]  = '{{6'b010100, 5'd9, 5'd10, 5'd11, 11'h7FF}, 5'd9, 5'd10, 5'd11, 3'b111, 32'h0, 6'h00, 5'd0, 8'h08};
        vt[5]  = '{{6'b100000, 26'h3FF_FFFF}, 5'd0, 5'd0, 5'd0, 3'b000, 32'hFFFF_FFFC, 6'h00, 5'd0, 8'h10};
        vt[6]  = '{{6'b100010, 5'd12, 21'h00_0003}, 5'd0, 5'd12, 5'd0, 3'b010, 32'h0000_000C, 6'h00, 5'd0, 8'h10};
        vt[7]  = '{{6'b100011, 5'd1, 21'h10_0000}, 5'd0, 5'd1, 5'd0, 3'b010, 32'hFFC0_0000, 6'h00, 5'd0, 8'h10};
        vt[8]  = '{{6'b111000, 26'd5}, 5'd0, 5'd0, 5'd0, 3'b000, 32'h0000_0005, 6'h00, 5'd0, 8'h02};
        vt[9]  = '{{6'b101101, 26'h3FF_FFFF}, 5'd0, 5'd0, 5'd0, 3'b000, 32'h0, 6'h00, 5'd0, 8'h01};
        vt[10] = '{{6'b001100, 5'd31, 5'd0, 16'h1234}, 5'd31, 5'd0, 5'd0, 3'b110, 32'h0000_1234, 6'h00, 5'd0, 8'h80};
        vt[11] = '{{6'b100001, 26'h200_0000}, 5'd30, 5'd0, 5'd0, 3'b100, 32'hF800_0000, 6'h00, 5'd0, 8'h14};
        vt[12] = '{{6'b010010, 5'd2, 5'd3, 16'h7FFF}, 5'd2, 5'd3, 5'd0, 3'b110, 32'h0000_7FFF, 6'h00, 5'd0, 8'h40};
        vt[13] = '{{6'b010011, 5'd8, 5'd9, 16'hFFFF}, 5'd0, 5'd9, 5'd8, 3'b011, 32'hFFFF_FFFF, 6'h00, 5'd0, 8'h20};
        vt[14] = '{{6'b001001, 5'd4, 5'd4, 16'h0000}, 5'd4, 5'd4, 5'd0, 3'b110, 32'h0, 6'h00, 5'd0, 8'h80};
        vt[15] = '{{6'b001101, 5'd4, 5'd4, 16'h0001}, 5'd0, 5'd0, 5'd0, 3'b000, 32'h0, 6'h00, 5'd0, 8'h01};

        reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
        fetch_valid = '0; fetch_instr = '0; fetch_pc = '0;
        #3;
        chk("reset_occ", 128'(occupancy), 128'(0));
        chk("reset_valid", 128'(out_valid), 128'(0));
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("reset_ready", 128'(fetch_ready), 128'(1));

        // ADDI + LDR pair
        fetch_valid    = 2'b11;
        fetch_instr[0] = {6'b001000, 5'd1, 5'd2, 16'hFFFC};
        fetch_instr[1] = {6'b010000, 5'd3, 5'd1, 16'h0008};
        fetch_pc[0]    = 32'h100; fetch_pc[1] = 32'h104;
        tick();
        fetch_valid = '0;
        chk("pair_valid", 128'(out_valid), 128'(2'b11));
        chk("pair_imm0", 128'(out_imm[0]), 128'(32'hFFFF_FFFC));
        chk("pair_alu0", 128'(out_is_alu[0]), 128'(1));
        chk("pair_lane1", 128'({out_imm[1], out_is_load[1], out_rd[1], out_rs1[1]}),
            128'({32'h8, 1'b1, 5'd3, 5'd1}));
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("pair_drain", 128'(occupancy), 128'(0));

        // BL #+4 in lane 1 only, compacted to out lane 0
        fetch_valid    = 2'b10;
        fetch_instr[1] = {6'b100001, 26'd4};
        fetch_pc[1]    = 32'h200;
        tick();
        fetch_valid = '0;
        chk("bl_valid", 128'(out_valid), 128'(2'b01));
        chk("bl_fields", 128'({out_rd[0], out_rd_valid[0], out_is_link[0], out_imm[0], out_pc[0]}),
            128'({5'd30, 1'b1, 1'b1, 32'h10, 32'h200}));
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Decode vector table
        for (int i = 0; i < 16; i++) begin
            vec_pc         = 32'h1000 + 32'(i * 4);
            fetch_valid    = 2'b01;
            fetch_instr[0] = vt[i].instr;
            fetch_pc[0]    = vec_pc;
            tick();
            fetch_valid = '0;
            exp_flat = {vt[i].instr[31:26], vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].v,
                        vt[i].imm, vec_pc, vt[i].func, vt[i].sh, vt[i].fl};
            chk($sformatf("vec%0d_valid", i), 128'(out_valid), 128'(2'b01));
            chk($sformatf("vec%0d_rec", i), 128'(lane0_flat()), 128'(exp_flat));
            out_ready = 1'b1; tick(); out_ready = 1'b0;
        end

        // Fill to backpressure, then drain in order; second round wraps pointers
        tag = 32'h4000;
        for (int round = 0; round < 2; round++) begin
            m_occ = 0;
            drive(2'b01, tag, 32'h0);
            #1 chk("fill_ready_first", 128'(fetch_ready), 128'(1));
            sb.push_back(tag); tag += 4; m_occ = 1;
            tick();
            for (int g = 0; g < 4; g++) begin
                drive(2'b11, tag, tag + 4);
                #1 chk($sformatf("fill_ready_occ%0d", m_occ), 128'(fetch_ready), 128'(m_occ <= 6));
                if (m_occ <= 6) begin
                    sb.push_back(tag); sb.push_back(tag + 4); m_occ += 2;
                end
                tag += 8;
                tick();
            end
            chk("fill_occ", 128'(occupancy), 128'(7));
            fetch_valid = '0;
            out_ready   = 1'b1;
            for (int c = 0; c < 10 && m_occ > 0; c++) begin
                chk("drain_valid", 128'(out_valid), 128'(m_occ >= 2 ? 2'b11 : 2'b01));
                chk("drain_pc0", 128'(out_pc[0]), 128'(sb[0]));
                void'(sb.pop_front());
                m_occ--;
                if (m_occ > 0) begin
                    chk("drain_pc1", 128'(out_pc[1]), 128'(sb[0]));
                    void'(sb.pop_front());
                    m_occ--;
                end
                tick();
            end
            out_ready = 1'b0;
            chk("drain_empty", 128'(occupancy), 128'(0));
        end

        // Steady-state throughput with continuous fetch and rename
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            drive(2'b11, tag, tag + 4);
            sb.push_back(tag); sb.push_back(tag + 4);
            tag += 8;
            tick();
            chk("thru_occ", 128'(occupancy), 128'(2));
            chk("thru_pcs", 128'({out_valid, out_pc[0], out_pc[1]}), 128'({2'b11, sb[0], sb[1]}));
            void'(sb.pop_front()); void'(sb.pop_front());
        end
        fetch_valid = '0;
        tick();
        out_ready = 1'b0;
        chk("thru_empty", 128'(occupancy), 128'(0));

        // Flush at occupancy 5 with concurrent fetch and dequeue
        drive(2'b01, tag, 32'h0); tick();
        drive(2'b11, tag + 4, tag + 8); tick();
        drive(2'b11, tag + 12, tag + 16); tick();
        chk("flush_pre_occ", 128'(occupancy), 128'(5));
        tag += 20;
        drive(2'b11, tag, tag + 4);
        out_ready = 1'b1;
        flush     = 1'b1;
        #1 chk("flush_ready_low", 128'(fetch_ready), 128'(0));
        tick();
        flush = 1'b0; out_ready = 1'b0; fetch_valid = '0;
        chk("flush_occ", 128'(occupancy), 128'(0));
        chk("flush_valid", 128'(out_valid), 128'(0));
        #1 chk("flush_ready_back", 128'(fetch_ready), 128'(1));
        tag += 8;
        drive(2'b01, tag, 32'h0); tick();
        fetch_valid = '0;
        chk("post_flush_pc", 128'({out_valid, out_pc[0]}), 128'({2'b01, tag}));

        // Asynchronous reset mid-stream
        drive(2'b11, tag + 4, tag + 8); tick();
        fetch_valid = '0;
        #2 reset = 1'b0;
        #1;
        chk("areset_occ", 128'(occupancy), 128'(0));
        chk("areset_valid", 128'(out_valid), 128'(0));
        chk("areset_fields", 128'({out_pc[0], out_imm[0], out_is_alu[0]}), 128'(0));
        #1 reset = 1'b1;
        tick();
        chk("areset_hold", 128'(occupancy), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
